// File: rtl/noc_local_port_bridge.sv
// ============================================================================
// noc_local_port_bridge : per-VC injection FIFOs with packet-locked RR arbiter,
// plus a registered ejection stage with packet-framing checker.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_local_port_bridge #(
  parameter int DATA_W      = 32,
  parameter int NUM_VC      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                                      noc_clk,
  input  logic                                      noc_rst,
  input  logic [NUM_VC-1:0]                         inj_valid,
  output logic [NUM_VC-1:0]                         inj_ready,
  input  logic [NUM_VC*DATA_W-1:0]                  inj_data,
  input  logic [NUM_VC-1:0]                         inj_is_header,
  input  logic [NUM_VC-1:0]                         inj_is_tail,
  output logic                                      fab_tx_valid,
  output logic [((NUM_VC>1)?$clog2(NUM_VC):1)-1:0]  fab_tx_vc,
  output logic [DATA_W+1:0]                         fab_tx_flit,
  input  logic [NUM_VC-1:0]                         fab_tx_vc_ready,
  input  logic                                      fab_rx_valid,
  output logic                                      fab_rx_ready,
  input  logic [DATA_W+1:0]                         fab_rx_flit,
  output logic                                      ej_valid,
  input  logic                                      ej_ready,
  output logic [DATA_W-1:0]                         ej_data,
  output logic                                      ej_is_header,
  output logic                                      ej_is_tail,
  output logic [7:0]                                ej_pkt_len,
  output logic                                      err_valid,
  output logic [1:0]                                err_code
);

  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int FLIT_W = DATA_W + 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] eligible;
  logic [FLIT_W-1:0] head [NUM_VC];

  logic              grant_found;
  logic [VC_W-1:0]   grant_vc;
  logic [VC_W:0]     rr_idx;
  logic              transfer;
  logic              locked;
  logic [VC_W-1:0]   lock_vc;
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   rr_next;

  // ---------------------------------------------------------------- injection
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    assign full[v]      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty[v]     = (count == '0);
    assign inj_ready[v] = !full[v];
    assign push         = inj_valid[v] && !full[v];
    assign pop          = transfer && (grant_vc == VC_W'(v));
    assign head[v]      = mem[rd_ptr];

    always_ff @(posedge noc_clk) begin
      if (push) begin
        mem[wr_ptr] <= {inj_is_header[v], inj_is_tail[v], inj_data[v*DATA_W +: DATA_W]};
      end
    end

    always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- arbiter
  assign eligible = ~empty & fab_tx_vc_ready;

  // Descending scan so the VC closest to rr_ptr is the last (winning) write.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = '0;
    rr_idx      = '0;
    if (locked) begin
      if (eligible[lock_vc]) begin
        grant_found = 1'b1;
        grant_vc    = lock_vc;
      end
    end else begin
      for (int i = NUM_VC - 1; i >= 0; i--) begin
        rr_idx = {1'b0, rr_ptr} + (VC_W+1)'(i);
        if (rr_idx >= (VC_W+1)'(NUM_VC)) rr_idx = rr_idx - (VC_W+1)'(NUM_VC);
        if (eligible[rr_idx[VC_W-1:0]]) begin
          grant_found = 1'b1;
          grant_vc    = rr_idx[VC_W-1:0];
        end
      end
    end
  end

  assign fab_tx_valid = grant_found && !noc_rst;
  assign fab_tx_vc    = grant_vc;
  assign fab_tx_flit  = head[grant_vc];
  assign transfer     = fab_tx_valid && fab_tx_vc_ready[grant_vc];
  assign rr_next      = (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + VC_W'(1);

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      locked  <= 1'b0;
      lock_vc <= '0;
      rr_ptr  <= '0;
    end else if (transfer) begin
      if (fab_tx_flit[DATA_W]) begin
        locked <= 1'b0;
        rr_ptr <= rr_next;
      end else if (fab_tx_flit[FLIT_W-1]) begin
        locked  <= 1'b1;
        lock_vc <= grant_vc;
      end
    end
  end

  // ---------------------------------------------------------------- ejection
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } chk_state_t;

  chk_state_t state_q, state_d;
  logic [7:0] len_q, len_d, len_inc;
  logic       ovf_q, ovf_d;
  logic [1:0] code_d;
  logic       capture;
  logic       rx_hdr;
  logic       rx_tail;

  assign fab_rx_ready = !ej_valid || ej_ready;
  assign capture      = fab_rx_valid && fab_rx_ready;
  assign rx_hdr       = fab_rx_flit[FLIT_W-1];
  assign rx_tail      = fab_rx_flit[DATA_W];
  assign len_inc      = (len_q == 8'd255) ? 8'd255 : len_q + 8'd1;
  assign ej_pkt_len   = len_q;

  // A header always restarts framing, even when it also reports an error.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    code_d  = 2'd0;
    if (capture) begin
      if (rx_hdr) begin
        if (state_q == ST_IN_PKT) code_d = 2'd2;
        len_d   = 8'd1;
        ovf_d   = 1'b0;
        state_d = rx_tail ? ST_IDLE : ST_IN_PKT;
      end else if (state_q == ST_IDLE) begin
        code_d = 2'd1;
        len_d  = 8'd0;
      end else begin
        len_d = len_inc;
        if (rx_tail) state_d = ST_IDLE;
        if (int'(len_inc) > MAX_PKT_LEN && !ovf_q) begin
          code_d = 2'd3;
          ovf_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      ej_valid     <= 1'b0;
      ej_data      <= '0;
      ej_is_header <= 1'b0;
      ej_is_tail   <= 1'b0;
      err_valid    <= 1'b0;
      err_code     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      err_valid <= (code_d != 2'd0);
      err_code  <= code_d;
      if (capture) begin
        ej_valid     <= 1'b1;
        ej_data      <= fab_rx_flit[DATA_W-1:0];
        ej_is_header <= rx_hdr;
        ej_is_tail   <= rx_tail;
      end else if (ej_ready) begin
        ej_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_local_port_bridge.sv
// ============================================================================
// tb_noc_local_port_bridge : directed self-checking bench for the bridge. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_noc_local_port_bridge;

  localparam int DW = 32;
  localparam int NV = 2;
  localparam int FW = DW + 2;

  logic             noc_clk;
  logic             noc_rst;
  logic [NV-1:0]    inj_valid;
  logic [NV-1:0]    inj_ready;
  logic [NV*DW-1:0] inj_data;
  logic [NV-1:0]    inj_is_header;
  logic [NV-1:0]    inj_is_tail;
  logic             fab_tx_valid;
  logic [0:0]       fab_tx_vc;
  logic [FW-1:0]    fab_tx_flit;
  logic [NV-1:0]    fab_tx_vc_ready;
  logic             fab_rx_valid;
  logic             fab_rx_ready;
  logic [FW-1:0]    fab_rx_flit;
  logic             ej_valid;
  logic             ej_ready;
  logic [DW-1:0]    ej_data;
  logic             ej_is_header;
  logic             ej_is_tail;
  logic [7:0]       ej_pkt_len;
  logic             err_valid;
  logic [1:0]       err_code;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int            mon_cyc  [$];
  int            mon_vc   [$];
  logic [FW-1:0] mon_flit [$];

  noc_local_port_bridge #(
    .DATA_W(DW), .NUM_VC(NV), .FIFO_DEPTH(4), .MAX_PKT_LEN(16)
  ) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_data(inj_data),
    .inj_is_header(inj_is_header), .inj_is_tail(inj_is_tail),
    .fab_tx_valid(fab_tx_valid), .fab_tx_vc(fab_tx_vc), .fab_tx_flit(fab_tx_flit),
    .fab_tx_vc_ready(fab_tx_vc_ready),
    .fab_rx_valid(fab_rx_valid), .fab_rx_ready(fab_rx_ready), .fab_rx_flit(fab_rx_flit),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_data(ej_data),
    .ej_is_header(ej_is_header), .ej_is_tail(ej_is_tail), .ej_pkt_len(ej_pkt_len),
    .err_valid(err_valid), .err_code(err_code)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;
  always @(posedge noc_clk) cyc = cyc + 1;

  // Fabric-side transfer log, taken mid-cycle.
  always @(negedge noc_clk) begin
    if (fab_tx_valid && fab_tx_vc_ready[fab_tx_vc]) begin
      mon_cyc.push_back(cyc);
      mon_vc.push_back(int'(fab_tx_vc));
      mon_flit.push_back(fab_tx_flit);
    end
  end

  function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [DW-1:0] d);
    return {h, t, d};
  endfunction

  task automatic step();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic set_inj(input int v, input logic vld, input logic h, input logic t,
                         input logic [DW-1:0] d);
    inj_valid[v]          = vld;
    inj_is_header[v]      = h;
    inj_is_tail[v]        = t;
    inj_data[v*DW +: DW]  = d;
  endtask

  task automatic apply_reset();
    noc_rst         = 1'b1;
    inj_valid       = '0;
    inj_is_header   = '0;
    inj_is_tail     = '0;
    inj_data        = '0;
    fab_tx_vc_ready = '1;
    fab_rx_valid    = 1'b0;
    fab_rx_flit     = '0;
    ej_ready        = 1'b1;
    step();
    noc_rst = 1'b0;
    mon_cyc.delete();
    mon_vc.delete();
    mon_flit.delete();
  endtask

  task automatic rx_send(input logic h, input logic t, input logic [DW-1:0] d);
    fab_rx_valid = 1'b1;
    fab_rx_flit  = mk(h, t, d);
    step();
    fab_rx_valid = 1'b0;
    @(negedge noc_clk);
  endtask

  task automatic test_reset();
    apply_reset();
    fab_tx_vc_ready = '0;
    set_inj(0, 1'b1, 1'b1, 1'b0, 32'hDEAD_0000);
    set_inj(1, 1'b1, 1'b1, 1'b0, 32'hDEAD_0001);
    step();
    inj_valid       = '0;
    noc_rst         = 1'b1;
    fab_tx_vc_ready = '1;
    step();
    noc_rst = 1'b0;
    @(negedge noc_clk);
    checks++; if (inj_ready !== 2'b11) begin errors++; $display("FAIL reset_inj_ready: got %b want 11", inj_ready); end
    checks++; if (fab_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", fab_tx_valid); end
    checks++; if (ej_valid !== 1'b0 || ej_data !== '0 || ej_pkt_len !== 8'd0) begin
      errors++; $display("FAIL reset_ej: valid=%b data=%h len=%0d want 0/0/0", ej_valid, ej_data, ej_pkt_len);
    end
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd0) begin
      errors++; $display("FAIL reset_err: valid=%b code=%0d want 0/0", err_valid, err_code);
    end
    checks++; if (fab_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", fab_rx_ready); end
    repeat (3) step();
    checks++; if (mon_flit.size() != 0) begin errors++; $display("FAIL reset_discard: got %0d flits want 0", mon_flit.size()); end
  endtask

  task automatic test_single_pkt();
    int base;
    logic [FW-1:0] exp_f [3];
    apply_reset();
    base = cyc;
    exp_f[0] = mk(1'b1, 1'b0, 32'hA000_0001);
    exp_f[1] = mk(1'b0, 1'b0, 32'hA000_0002);
    exp_f[2] = mk(1'b0, 1'b1, 32'hA000_0003);
    for (int i = 0; i < 3; i++) begin
      set_inj(0, 1'b1, exp_f[i][FW-1], exp_f[i][DW], exp_f[i][DW-1:0]);
      step();
    end
    inj_valid = '0;
    repeat (3) step();
    checks++; if (mon_flit.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", mon_flit.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mon_vc[i] != 0 || mon_flit[i] !== exp_f[i] || mon_cyc[i] != base + 1 + i) begin
        errors++;
        $display("FAIL single_flit%0d: vc=%0d flit=%h cyc=%0d want vc=0 flit=%h cyc=%0d",
                 i, mon_vc[i], mon_flit[i], mon_cyc[i], exp_f[i], base + 1 + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int            exp_v [4];
    logic [FW-1:0] exp_f [4];
    apply_reset();
    exp_v = '{0, 0, 1, 1};
    exp_f[0] = mk(1'b1, 1'b0, 32'hB000_0000);
    exp_f[1] = mk(1'b0, 1'b1, 32'hB000_0001);
    exp_f[2] = mk(1'b1, 1'b0, 32'hB100_0000);
    exp_f[3] = mk(1'b0, 1'b1, 32'hB100_0001);
    set_inj(0, 1'b1, 1'b1, 1'b0, 32'hB000_0000);
    set_inj(1, 1'b1, 1'b1, 1'b0, 32'hB100_0000);
    step();
    set_inj(0, 1'b1, 1'b0, 1'b1, 32'hB000_0001);
    set_inj(1, 1'b1, 1'b0, 1'b1, 32'hB100_0001);
    step();
    inj_valid = '0;
    repeat (6) step();
    checks++; if (mon_flit.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", mon_flit.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mon_vc[i] != exp_v[i] || mon_flit[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL b2b_order%0d: vc=%0d flit=%h want vc=%0d flit=%h", i, mon_vc[i], mon_flit[i], exp_v[i], exp_f[i]);
      end
    end
    checks++; if (dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL b2b_rr_ptr: got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_lock_stall();
    int            exp_v [5];
    logic [FW-1:0] exp_f [5];
    apply_reset();
    exp_v = '{0, 0, 0, 1, 1};
    exp_f[0] = mk(1'b1, 1'b0, 32'hC000_0000);
    exp_f[1] = mk(1'b0, 1'b0, 32'hC000_0001);
    exp_f[2] = mk(1'b0, 1'b1, 32'hC000_0002);
    exp_f[3] = mk(1'b1, 1'b0, 32'hC100_0000);
    exp_f[4] = mk(1'b0, 1'b1, 32'hC100_0001);
    set_inj(0, 1'b1, 1'b1, 1'b0, 32'hC000_0000);
    set_inj(1, 1'b1, 1'b1, 1'b0, 32'hC100_0000);
    step();
    set_inj(0, 1'b1, 1'b0, 1'b0, 32'hC000_0001);
    set_inj(1, 1'b1, 1'b0, 1'b1, 32'hC100_0001);
    step();
    set_inj(0, 1'b1, 1'b0, 1'b1, 32'hC000_0002);
    set_inj(1, 1'b0, 1'b0, 1'b0, 32'h0);
    fab_tx_vc_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge noc_clk);
      checks++;
      if (fab_tx_valid !== 1'b0) begin errors++; $display("FAIL lock_stall_c%0d: tx_valid=%b want 0", k, fab_tx_valid); end
      step();
      inj_valid = '0;
    end
    fab_tx_vc_ready = 2'b11;
    repeat (6) step();
    checks++; if (mon_flit.size() != 5) begin errors++; $display("FAIL lock_count: got %0d want 5", mon_flit.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mon_vc[i] != exp_v[i] || mon_flit[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL lock_order%0d: vc=%0d flit=%h want vc=%0d flit=%h", i, mon_vc[i], mon_flit[i], exp_v[i], exp_f[i]);
      end
    end
    checks++; if (mon_cyc[1] - mon_cyc[0] != 6) begin
      errors++; $display("FAIL lock_gap: got %0d cycles want 6", mon_cyc[1] - mon_cyc[0]);
    end
  endtask

  task automatic test_fifo_full();
    logic got;
    apply_reset();
    fab_tx_vc_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      set_inj(1, 1'b1, 1'b1, 1'b1, 32'(k));
      @(negedge noc_clk);
      checks++;
      if (inj_ready[1] !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d: got %b want 1", k, inj_ready[1]); end
      step();
    end
    set_inj(1, 1'b1, 1'b1, 1'b1, 32'd4);
    @(negedge noc_clk);
    checks++; if (inj_ready[1] !== 1'b0) begin errors++; $display("FAIL full_ready_after4: got %b want 0", inj_ready[1]); end
    step();
    @(negedge noc_clk);
    checks++; if (inj_ready[1] !== 1'b0 || mon_flit.size() != 0) begin
      errors++; $display("FAIL full_hold: ready=%b sent=%0d want 0/0", inj_ready[1], mon_flit.size());
    end
    fab_tx_vc_ready = 2'b10;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge noc_clk);
      if (inj_ready[1]) got = 1'b1;
      step();
    end
    inj_valid = '0;
    checks++; if (!got) begin errors++; $display("FAIL full_accept_timeout: accepted=0 want 1"); end
    repeat (8) step();
    checks++; if (mon_flit.size() != 5) begin errors++; $display("FAIL full_drain_count: got %0d want 5", mon_flit.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mon_vc[i] != 1 || mon_flit[i] !== mk(1'b1, 1'b1, 32'(i))) begin
        errors++; $display("FAIL full_drain%0d: vc=%0d flit=%h want vc=1 flit=%h", i, mon_vc[i], mon_flit[i], mk(1'b1, 1'b1, 32'(i)));
      end
    end
  endtask

  task automatic test_ejection_errors();
    int pulses;
    apply_reset();
    @(negedge noc_clk);
    rx_send(1'b0, 1'b0, 32'hE000_0001);
    checks++; if (ej_valid !== 1'b1 || err_valid !== 1'b1 || err_code !== 2'd1 || ej_pkt_len !== 8'd0 || ej_data !== 32'hE000_0001) begin
      errors++; $display("FAIL ej_orphan: v=%b ev=%b code=%0d len=%0d data=%h want 1/1/1/0/e0000001",
                         ej_valid, err_valid, err_code, ej_pkt_len, ej_data);
    end
    rx_send(1'b1, 1'b0, 32'hE000_0002);
    checks++; if (err_valid !== 1'b0 || ej_pkt_len !== 8'd1 || ej_is_header !== 1'b1) begin
      errors++; $display("FAIL ej_hdr: ev=%b len=%0d hdr=%b want 0/1/1", err_valid, ej_pkt_len, ej_is_header);
    end
    rx_send(1'b1, 1'b0, 32'hE000_0003);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2 || ej_pkt_len !== 8'd1) begin
      errors++; $display("FAIL ej_hdr_in_pkt: ev=%b code=%0d len=%0d want 1/2/1", err_valid, err_code, ej_pkt_len);
    end
    rx_send(1'b0, 1'b1, 32'hE000_0004);
    checks++; if (err_valid !== 1'b0 || ej_pkt_len !== 8'd2 || ej_is_tail !== 1'b1) begin
      errors++; $display("FAIL ej_tail: ev=%b len=%0d tail=%b want 0/2/1", err_valid, ej_pkt_len, ej_is_tail);
    end
    pulses = 0;
    for (int i = 1; i <= 17; i++) begin
      rx_send(i == 1, i == 17, 32'hF000_0000 + 32'(i));
      if (err_valid) pulses++;
      if (i == 16) begin
        checks++; if (err_valid !== 1'b0 || ej_pkt_len !== 8'd16) begin
          errors++; $display("FAIL ej_len16: ev=%b len=%0d want 0/16", err_valid, ej_pkt_len);
        end
      end
      if (i == 17) begin
        checks++; if (err_valid !== 1'b1 || err_code !== 2'd3 || ej_pkt_len !== 8'd17) begin
          errors++; $display("FAIL ej_len17: ev=%b code=%0d len=%0d want 1/3/17", err_valid, err_code, ej_pkt_len);
        end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ej_ovf_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_ej_backpressure_reset();
    apply_reset();
    @(negedge noc_clk);
    ej_ready = 1'b0;
    rx_send(1'b1, 1'b0, 32'h5100_0001);
    fab_rx_valid = 1'b1;
    fab_rx_flit  = mk(1'b0, 1'b0, 32'h5100_0002);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fab_rx_ready !== 1'b0 || ej_valid !== 1'b1 || ej_data !== 32'h5100_0001 || ej_is_header !== 1'b1) begin
        errors++; $display("FAIL ej_stall%0d: rdy=%b v=%b data=%h hdr=%b want 0/1/51000001/1",
                           k, fab_rx_ready, ej_valid, ej_data, ej_is_header);
      end
      @(negedge noc_clk);
    end
    ej_ready = 1'b1;
    step();
    fab_rx_valid = 1'b0;
    ej_ready     = 1'b0;
    @(negedge noc_clk);
    checks++; if (ej_data !== 32'h5100_0002 || ej_pkt_len !== 8'd2 || ej_valid !== 1'b1) begin
      errors++; $display("FAIL ej_release: data=%h len=%0d v=%b want 51000002/2/1", ej_data, ej_pkt_len, ej_valid);
    end
    noc_rst      = 1'b1;
    fab_rx_valid = 1'b1;
    fab_rx_flit  = mk(1'b0, 1'b0, 32'h5100_0003);
    step();
    noc_rst      = 1'b0;
    fab_rx_valid = 1'b0;
    @(negedge noc_clk);
    checks++; if (ej_valid !== 1'b0 || ej_data !== '0 || ej_pkt_len !== 8'd0 || ej_is_header !== 1'b0 ||
                  ej_is_tail !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'd0 || fab_tx_valid !== 1'b0) begin
      errors++; $display("FAIL ej_midpkt_reset: v=%b data=%h len=%0d hdr=%b tail=%b ev=%b code=%0d tx=%b want all 0",
                         ej_valid, ej_data, ej_pkt_len, ej_is_header, ej_is_tail, err_valid, err_code, fab_tx_valid);
    end
    ej_ready = 1'b1;
    rx_send(1'b0, 1'b1, 32'h5100_0004);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd1 || ej_pkt_len !== 8'd0) begin
      errors++; $display("FAIL ej_idle_after_reset: ev=%b code=%0d len=%0d want 1/1/0", err_valid, err_code, ej_pkt_len);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_lock_stall();
    test_fifo_full();
    test_ejection_errors();
    test_ej_backpressure_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/noc_local_port_bridge.md
NOC_LOCAL_PORT_BRIDGE -- requirements
Module: noc_local_port_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, flit payload width excluding header/tail bits.
REQ-002 SHALL have parameter NUM_VC, default 2, number of injection virtual channels (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, per-VC injection FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_PKT_LEN, default 16, longest legal ejected packet in flits, header and tail included.
REQ-005 SHALL have ports: noc_clk  in  1  sole clock.
REQ-006 noc_rst  in  1  reset, synchronous, active-high.
REQ-007 inj_valid  in  NUM_VC; inj_ready  out  NUM_VC; inj_data  in  NUM_VC*DATA_W; inj_is_header  in  NUM_VC; inj_is_tail  in  NUM_VC; VC v uses slice v.
REQ-008 fab_tx_valid  out  1; fab_tx_vc  out  max(1,clog2(NUM_VC)); fab_tx_flit  out  DATA_W+2; fab_tx_vc_ready  in  NUM_VC, per-VC downstream space.
REQ-009 fab_rx_valid  in  1; fab_rx_ready  out  1; fab_rx_flit  in  DATA_W+2.
REQ-010 ej_valid  out  1; ej_ready  in  1; ej_data  out  DATA_W; ej_is_header  out  1; ej_is_tail  out  1; ej_pkt_len  out  8, flit index within packet (header=1).
REQ-011 err_valid  out  1, one-cycle pulse; err_code  out  2: 1=orphan body/tail, 2=header inside packet, 3=length overflow.
REQ-012 Flit format SHALL be {header bit [DATA_W+1], tail bit [DATA_W], data [DATA_W-1:0]}.

Function
REQ-013 Injection: inj_ready[v] = !full[v] (registered state only); push on inj_valid[v]&&inj_ready[v]; no push when full even if pop same cycle.
REQ-014 FIFOs SHALL have no bypass; flit pushed in cycle t is earliest on fab_tx in cycle t+1.
REQ-015 fab_tx output SHALL be combinational from FIFO heads and arbiter state; transfer = fab_tx_valid && fab_tx_vc_ready[fab_tx_vc]; pop on transfer.
REQ-016 VC v eligible when FIFO v non-empty and fab_tx_vc_ready[v]=1; fab_tx_valid=1 iff a VC is granted; fab_tx_valid never depends on a stalled-VC's state.
REQ-017 Arbiter: round-robin from rr_ptr when unlocked; when locked, only lock_vc may be granted, else fab_tx_valid=0.
REQ-018 Lock SHALL set to granted VC on transfer of header flit with tail=0; clear on transfer of tail flit; single-flit packet (header&tail) never locks.
REQ-019 rr_ptr SHALL advance to (granted VC+1) mod NUM_VC on every tail-flit transfer, wrap at NUM_VC-1 -> 0.
REQ-020 Ejection: one register stage; fab_rx_ready = !ej_valid || ej_ready; flit captured on fab_rx_valid&&fab_rx_ready; ej_valid cleared on ej_ready with no new capture.
REQ-021 Checker FSM states IDLE, IN_PKT, evaluated on captured flit: IDLE+header&!tail -> IN_PKT, len=1; IDLE+header&tail -> IDLE, len=1; IDLE+non-header -> IDLE, err 1, len=0.
REQ-022 IN_PKT+header -> err 2, treated as new header (len=1, state by its tail bit); IN_PKT+body -> len+1; IN_PKT+tail -> IDLE, len+1.
REQ-023 len exceeding MAX_PKT_LEN SHALL pulse err 3 once per packet; len saturates at 255.
REQ-024 All errored flits SHALL still be forwarded to ej; err_valid aligns with ej_valid rising for that flit; simultaneous errors report lowest code.

Reset
REQ-025 On noc_rst: FIFOs emptied, inj_ready=all 1s on next cycle, fab_tx_valid=0, lock cleared, rr_ptr=0, ej_valid=0, ej outputs 0, FSM=IDLE, len=0, err_valid=0, err_code=0.
REQ-026 Reset asserted mid-packet SHALL discard queued and partial packets; no flit emitted in reset cycle's following edge.

Verification
REQ-027 Single VC0 3-flit packet (H,B,T), vc_ready=all 1 -> fab_tx_vc=0 three consecutive cycles starting cycle after first push, flits in order.
REQ-028 VC0 and VC1 both hold 2-flit packets, rr_ptr=0 -> VC0 H,T then VC1 H,T; no interleave; rr_ptr ends 0.
REQ-029 VC0 locked after header, fab_tx_vc_ready[0]=0 for 5 cycles, VC1 non-empty -> fab_tx_valid=0 for 5 cycles, VC0 resumes.
REQ-030 Fill VC1 with FIFO_DEPTH=4 flits, vc_ready=0 -> inj_ready[1]=0 after 4th push; 5th flit held; release drains 4 then accepts.
REQ-031 Ejection: body flit in IDLE -> err_code=1; then H,H -> err_code=2, len=1; then 17-flit packet -> err_code=3 at flit 17 only.
REQ-032 ej_ready=0 with ej_valid=1 -> fab_rx_ready=0, ej outputs stable; reset mid-packet -> all outputs 0 next cycle, FSM IDLE.
